// File: rtl/fetch_stage.sv
// fetch_stage: PC register plus the IF/ID pipeline register with stall, flush and redirect.
// Every output comes straight from a flop; InstrF is sampled in the same cycle as PCF.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchCount
);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pcd_q, pcd_d, pc4d_q, pc4d_d, count_q, count_d;
    logic        valid_q, valid_d, load;
    logic [31:0] pc_plus4;
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        load     = !FlushD && !StallD;
        pc_d     = PCSrcE ? {PCTargetE[31:2], 2'b00} : StallF ? pc_q : pc_plus4;
        instr_d  = FlushD ? NOP_INSTR : StallD ? instr_q : InstrF;
        pcd_d    = FlushD ? 32'd0 : StallD ? pcd_q : pc_q;
        pc4d_d   = FlushD ? 32'd0 : StallD ? pc4d_q : pc_plus4;
        valid_d  = FlushD ? 1'b0 : StallD ? valid_q : 1'b1;
        count_d  = load ? count_q + 32'd1 : count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pc4d_q  <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc4d_q  <= pc4d_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end
    assign PCF        = pc_q;
    assign InstrD     = instr_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pc4d_q;
    assign ValidD     = valid_q;
    assign FetchCount = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed fetch traffic scored against a queue-fed reference model.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h00000000;
    localparam logic [31:0] NOP    = 32'h00000013;
    typedef struct packed {
        logic [31:0] pcf, instr, pcd, pc4, cnt;
        logic        valid;
    } exp_t;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
    logic [31:0] pc_target_e = 32'd0;
    logic [31:0] pcf, instr_f, instr_d, pcd, pc4d, fetch_count;
    logic        valid_d;
    logic [31:0] mem [256];
    exp_t        q [$];
    int          n_vec = 0, n_bad = 0;
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
    logic        m_valid;
    always #5 clk = ~clk;
    assign instr_f = mem[pcf[9:2]];
    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
        .PCSrcE(pc_src_e), .PCTargetE(pc_target_e), .PCF(pcf), .InstrF(instr_f),
        .InstrD(instr_d), .PCD(pcd), .PCPlus4D(pc4d), .ValidD(valid_d), .FetchCount(fetch_count)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic m_reset();
        m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    endtask
    // Reference: one clock edge of a fetch stage, IF/ID captures the pre-edge PC.
    task automatic m_edge();
        if (!rst_n) m_reset();
        else begin
            if (flush_d) begin
                m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
            end else if (!stall_d) begin
                m_instr = mem[m_pc[9:2]]; m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1; m_cnt++;
            end
            if (pc_src_e) m_pc = pc_target_e & 32'hFFFFFFFC;
            else if (!stall_f) m_pc = m_pc + 4;
        end
        q.push_back('{pcf: m_pc, instr: m_instr, pcd: m_pcd, pc4: m_pc4, cnt: m_cnt, valid: m_valid});
    endtask
    task automatic step(input logic sf, input logic sd, input logic fd, input logic ps, input logic [31:0] tgt);
        stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = ps; pc_target_e = tgt;
        @(posedge clk);
        m_edge();
        #1;
    endtask
    task automatic chk_reset_now(input string tag);
        chk({tag, "_pcf"}, pcf, RST_PC);
        chk({tag, "_instr"}, instr_d, NOP);
        chk({tag, "_pcd"}, pcd, 32'd0);
        chk({tag, "_pc4"}, pc4d, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
        chk({tag, "_cnt"}, fetch_count, 32'd0);
    endtask
    task automatic async_reset(input int hold);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_now("async_rst");
        m_reset();
        for (int i = 0; i < hold; i++) step($urandom, $urandom, $urandom, $urandom, $urandom);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            automatic exp_t e = q.pop_front();
            chk("sb_pcf", pcf, e.pcf);
            chk("sb_instr", instr_d, e.instr);
            chk("sb_pcd", pcd, e.pcd);
            chk("sb_pc4", pc4d, e.pc4);
            chk("sb_valid", {31'd0, valid_d}, {31'd0, e.valid});
            chk("sb_cnt", fetch_count, e.cnt);
        end
    end
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        m_reset();
        #2 rst_n = 1'b0;
        #1 chk_reset_now("por");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("seq_pcf", pcf, 32'd16);
        chk("seq_cnt", fetch_count, 32'd4);
        chk("seq_pcd", pcd, 32'd12);
        chk("seq_instr", instr_d, mem[3]);
        step(1, 0, 0, 1, 32'h203);
        chk("redirect_pcf", pcf, 32'h200);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("stall_pcf", pcf, 32'h200);
        chk("stall_cnt", fetch_count, 32'd5);
        chk("stall_instr", instr_d, mem[4]);
        step(1, 1, 1, 0, 0);
        chk("flush_instr", instr_d, NOP);
        chk("flush_valid", {31'd0, valid_d}, 32'd0);
        chk("flush_pcd", pcd, 32'd0);
        chk("flush_cnt", fetch_count, 32'd5);
        step(0, 0, 0, 1, 32'hFFFFFFFF);
        chk("wrap_target", pcf, 32'hFFFFFFFC);
        step(0, 0, 0, 0, 0);
        chk("wrap_pcf", pcf, 32'h00000000);
        chk("wrap_pc4d", pc4d, 32'h00000000);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) async_reset($urandom_range(0, 2));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0, $urandom);
        end
        step(0, 0, 0, 1, 32'h40);
        chk("pre_rst_pcf", pcf, 32'h40);
        chk("pre_rst_valid", {31'd0, valid_d}, 32'd1);
        async_reset(1);
        step(0, 0, 0, 0, 0);
        chk("resume_pcf", pcf, RST_PC + 4);
        chk("resume_pcd", pcd, RST_PC);
        @(negedge clk);
        #1;
        chk("sb_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
